rate_counter: RTL and testbench
===============================

Name: rate_counter

Overview:
Parametrised variable-rate counter for the lab boards. A prescaler generates a tick every `period` clock cycles, and an up/down counter advances on each tick. Four keys control `period`:
- two held keys nudge the period by STEP per cycle;
- two key releases double or halve the tick frequency.

It sits between the key inputs and the seven-segment/LED drivers of a lab top.

Parameters:
- W_CNT, 32, counter width in bits.
- W_PERIOD, 32, period and prescaler width in bits.
- MIN_PERIOD, 1000000, smallest allowed period in cycles; must be ≥ 1.
- MAX_PERIOD, 150000000, largest allowed period; must be ≥ MIN_PERIOD and < 2^W_PERIOD.
- RESET_PERIOD, (MIN_PERIOD+MAX_PERIOD)/2, period after reset; must lie in [MIN, MAX].
- STEP, 1, per-cycle nudge applied while a hold key is asserted.
- WRAP, 1, counter overflow mode: 1 wraps, 0 saturates.
- DEBOUNCE_CYCLES, 65536, filter length; used only with the optional feature.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset: asserted at 0, released synchronously to clk.
- en, input, 1, prescaler/counter enable; does not affect period control.
- key_slower, input, 1, held: period += STEP per cycle.
- key_faster, input, 1, held: period -= STEP per cycle.
- key_halve, input, 1, on release: frequency /2 (period ×2).
- key_double, input, 1, on release: frequency ×2 (period /2).
- dir, input, 1, count direction: 1 up, 0 down.
- load, input, 1, synchronous load of count.
- load_value, input, W_CNT, value for load.
- period, output, W_PERIOD, current period.
- tick, output, 1, one-cycle pulse per period.
- count, output, W_CNT, counter value.
- wrap, output, 1, one-cycle pulse when count wraps or hits a saturation limit.

Behaviour:
- Reset values:
  - period = RESET_PERIOD.
  - Prescaler = 0.
  - count = 0.
  - tick = 0, wrap = 0.
  - Key history registers = 0.
- Release detect, per key: prev registered each cycle; release = prev & ~key. A key held through reset release produces no event until it is released after reset.
- Period update uses one priority chain; exactly one action applies per cycle.
  1. key_slower and period < MAX: period = min(period+STEP, MAX).
  2. key_faster and period > MIN: period = max(period−STEP, MIN).
  3. Halve release: period = (period > MAX/2) ? MAX : period×2. Compute at W_PERIOD+1 bits; no overflow.
  4. Double release: period = (period/2 < MIN) ? MIN : period/2, using floor division.
  5. Otherwise period holds.
- Simultaneous events: a lower-priority release that coincides with a higher-priority action is dropped, not queued.
- Prescaler (down-counter):
  - When en=1 and prescaler==0: reload to period−1 and assert tick in the same cycle (combinational from the registered prescaler value).
  - When en=1 and prescaler≠0: decrement.
  - When en=0: hold; tick=0.
  - The first tick occurs on the first enabled cycle after reset.
  - A period change takes effect at the next reload; the current interval is not truncated.
  - With period==1, tick is high on every enabled cycle.
- Counter:
  - load has priority over tick: count = load_value; wrap = 0; the tick in that cycle is consumed.
  - On tick, up: count+1. At all-ones, WRAP=1 gives 0; WRAP=0 holds all-ones.
  - On tick, down: count−1. At 0, WRAP=1 gives all-ones; WRAP=0 holds 0.
  - wrap is registered and pulses in the cycle count updates at a limit, including saturating-hold ticks.
- Latency: period update visible 1 cycle after the triggering key edge; count updates 1 cycle after tick.
- Reset mid-operation: all state returns immediately to reset values; no pending events survive.

Optional Feature:
- Macro: RATE_COUNTER_DEBOUNCE_EN.
- Defined: each key passes through a 2-flop synchroniser. Then a stability counter sets the filtered level only after DEBOUNCE_CYCLES consecutive equal samples. Hold and release logic use the filtered level, adding DEBOUNCE_CYCLES+2 cycles of latency.
- Undefined: raw keys feed the logic directly and must already be synchronous to clk; DEBOUNCE_CYCLES is ignored.

Decomposition:
- Package rate_counter_pkg:
  - typedef period_t (W_PERIOD default), cnt_t;
  - enum key_idx_e {KEY_SLOWER, KEY_FASTER, KEY_HALVE, KEY_DOUBLE};
  - localparam helper for the MAX/2 threshold.
- Sub-module key_event: one per key. It contains the optional synchroniser and debouncer. Outputs are level and release_pulse.
- The top block holds the period chain, prescaler and counter.

Test Plan:
Parameters for all scenarios: MIN=4, MAX=64, RESET=16, STEP=1, W_CNT=8, en=1, macro off.
1. Reset release with no keys pressed → tick at cycles 0, 16, 32; count = 0, 1, 2.
2. Pulse key_halve (1 cycle high, then low) → period 32. Repeat twice → 64, then 64 (clamped). Pulse key_double from 64 → 32, then 16, 8, 4, 4.
3. Hold key_slower for 100 cycles from 16 → period increments each cycle and stops at 64. Hold key_slower and key_faster together → key_slower wins. Release key_halve while key_faster is held → release dropped.
4. WRAP=1, load 0xFE, dir=1 → count 0xFF, then 0x00 with wrap pulse. WRAP=0, dir=0, load 0x01 → 0x00, then 0x00 with wrap pulse on each further tick.
5. Change period from 16 to 32 mid-interval → the current interval completes at 16 and the next is 32. Drop en for 5 cycles → prescaler frozen, no tick.
6. Assert rst mid-count with key_halve held, then release rst → period=16, count=0. No halve event until key_halve is released. With macro on: a 3-cycle glitch on a key produces no event.

Source files
------------

// File: rtl/rate_counter_pkg.sv
// rate_counter_pkg: shared types, key indices and helpers for the variable-rate counter.
package rate_counter_pkg;

  localparam int W_CNT_DEF    = 32;
  localparam int W_PERIOD_DEF = 32;
  localparam int NUM_KEYS     = 4;

  typedef logic [W_PERIOD_DEF-1:0] period_t;
  typedef logic [W_CNT_DEF-1:0]    cnt_t;

  // Position of each control key in the per-key vectors of the top.
  typedef enum logic [1:0] {
    KEY_SLOWER = 2'd0,
    KEY_FASTER = 2'd1,
    KEY_HALVE  = 2'd2,
    KEY_DOUBLE = 2'd3
  } key_idx_e;

  // Above this period a doubling would overshoot the maximum, so it clamps instead.
  function automatic int unsigned halve_threshold(input int unsigned max_period);
    return max_period >> 1;
  endfunction

endpackage

// File: rtl/rate_counter_key_event.sv
// key_event: turns one key into a usable level and a one-cycle release pulse.
// With RATE_COUNTER_DEBOUNCE_EN defined the key is synchronised (2 flops) and
// debounced (DEBOUNCE_CYCLES equal samples) first; otherwise it is used as-is.
module key_event (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic level,
  output logic release_pulse
);

  logic prev_q, prev_d;

  // Key history: remembers last cycle's level for release detection.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    prev_d = level;
  end

  // History register, cleared by reset so a key held through reset gives no event.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    if (!rst) prev_q <= 1'b0;
    else      prev_q <= prev_d;
  end

  assign release_pulse = prev_q & ~level;

`ifdef RATE_COUNTER_DEBOUNCE_EN
  parameter int DEBOUNCE_CYCLES = 65536;
  localparam int W_DB = $clog2(DEBOUNCE_CYCLES + 1);

  logic            sync1_q, sync1_d, sync2_q, sync2_d;
  logic            filt_q, filt_d;
  logic [W_DB-1:0] stab_q, stab_d;

  // Synchroniser and stability filter: adopt a new level only after it has been
  // seen for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  always_comb begin
    sync1_d = key;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    stab_d  = stab_q;
    if (sync2_q == filt_q) begin
      stab_d = '0;
    end else if (stab_q == W_DB'(DEBOUNCE_CYCLES - 1)) begin
      filt_d = sync2_q;
      stab_d = '0;
    end else begin
      stab_d = stab_q + W_DB'(1);
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      stab_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      stab_q  <= stab_d;
    end
  end

  assign level = filt_q;
`else
  assign level = key;
`endif

endmodule

// File: rtl/rate_counter.sv
// rate_counter: key-controlled period register, tick prescaler and up/down counter.
// Optional RATE_COUNTER_DEBOUNCE_EN enables key synchronisation and debouncing
// (and the DEBOUNCE_CYCLES parameter); by default keys must be synchronous to clk.
module rate_counter
  import rate_counter_pkg::*;
#(
  parameter int W_CNT        = 32,
  parameter int W_PERIOD     = 32,
  parameter int MIN_PERIOD   = 1000000,
  parameter int MAX_PERIOD   = 150000000,
  parameter int RESET_PERIOD = (MIN_PERIOD + MAX_PERIOD) / 2,
  parameter int STEP         = 1,
  parameter int WRAP         = 1
`ifdef RATE_COUNTER_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_CYCLES = 65536
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                key_slower,
  input  logic                key_faster,
  input  logic                key_halve,
  input  logic                key_double,
  input  logic                dir,
  input  logic                load,
  input  logic [W_CNT-1:0]    load_value,
  output logic [W_PERIOD-1:0] period,
  output logic                tick,
  output logic [W_CNT-1:0]    count,
  output logic                wrap
);

  // Period arithmetic runs one bit wider so +STEP and x2 can never overflow.
  localparam logic [W_PERIOD:0]   MIN_X  = (W_PERIOD + 1)'(MIN_PERIOD);
  localparam logic [W_PERIOD:0]   MAX_X  = (W_PERIOD + 1)'(MAX_PERIOD);
  localparam logic [W_PERIOD:0]   STEP_X = (W_PERIOD + 1)'(STEP);
  localparam logic [W_PERIOD:0]   HALF_X = (W_PERIOD + 1)'(halve_threshold(MAX_PERIOD));
  localparam logic [W_PERIOD-1:0] MIN_P  = W_PERIOD'(MIN_PERIOD);
  localparam logic [W_PERIOD-1:0] MAX_P  = W_PERIOD'(MAX_PERIOD);
  localparam logic [W_PERIOD-1:0] RST_P  = W_PERIOD'(RESET_PERIOD);

  logic [NUM_KEYS-1:0] key_in, key_lvl, key_rel;

  assign key_in[KEY_SLOWER] = key_slower;
  assign key_in[KEY_FASTER] = key_faster;
  assign key_in[KEY_HALVE]  = key_halve;
  assign key_in[KEY_DOUBLE] = key_double;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
`ifdef RATE_COUNTER_DEBOUNCE_EN
    key_event #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
`else
    key_event u_key (
`endif
      .clk           (clk),
      .rst           (rst),
      .key           (key_in[i]),
      .level         (key_lvl[i]),
      .release_pulse (key_rel[i])
    );
  end

  logic [W_PERIOD-1:0] period_q, period_d;
  logic [W_PERIOD-1:0] presc_q, presc_d, half_p;
  logic [W_PERIOD:0]   period_x, inc_x, gap_x, dec_x, dbl_x;
  logic [W_CNT-1:0]    count_q, count_d;
  logic                wrap_q, wrap_d;

  assign period_x = {1'b0, period_q};
  assign inc_x    = period_x + STEP_X;
  assign gap_x    = period_x - MIN_X;
  assign dec_x    = period_x - STEP_X;
  assign dbl_x    = {period_q, 1'b0};
  assign half_p   = period_q >> 1;

  // Period priority chain: hold keys first, then halve release, then double release;
  // an event losing to a higher-priority action in the same cycle is discarded.
  always_comb begin
    period_d = period_q;
    if (key_lvl[KEY_SLOWER] && (period_x < MAX_X)) begin
      period_d = (inc_x > MAX_X) ? MAX_P : inc_x[W_PERIOD-1:0];
    end else if (key_lvl[KEY_FASTER] && (period_x > MIN_X)) begin
      period_d = (gap_x < STEP_X) ? MIN_P : dec_x[W_PERIOD-1:0];
    end else if (key_rel[KEY_HALVE]) begin
      period_d = (period_x > HALF_X) ? MAX_P : dbl_x[W_PERIOD-1:0];
    end else if (key_rel[KEY_DOUBLE]) begin
      period_d = (half_p < MIN_P) ? MIN_P : half_p;
    end
  end

  // Prescaler: ticks when it sits at zero, then reloads from the period in force now,
  // so a period change never truncates the interval already running.
  assign tick = en & (presc_q == '0);

  always_comb begin
    presc_d = presc_q;
    if (en) presc_d = (presc_q == '0) ? (period_q - W_PERIOD'(1)) : (presc_q - W_PERIOD'(1));
  end

  // Counter: load beats tick; a tick at a limit wraps or saturates and flags wrap.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_value;
    end else if (tick) begin
      if (dir) begin
        if (count_q == '1) begin
          wrap_d  = 1'b1;
          count_d = (WRAP != 0) ? '0 : '1;
        end else begin
          count_d = count_q + W_CNT'(1);
        end
      end else begin
        if (count_q == '0) begin
          wrap_d  = 1'b1;
          count_d = (WRAP != 0) ? '1 : '0;
        end else begin
          count_d = count_q - W_CNT'(1);
        end
      end
    end
  end

  // State registers for period, prescaler and counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_q <= RST_P;
      presc_q  <= '0;
      count_q  <= '0;
      wrap_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      presc_q  <= presc_d;
      count_q  <= count_d;
      wrap_q   <= wrap_d;
    end
  end

  assign period = period_q;
  assign count  = count_q;
  assign wrap   = wrap_q;

  // Outputs of the key blocks that this design does not need, plus carry-out bits.
  logic unused_ok;
  assign unused_ok = ^{key_lvl[KEY_HALVE], key_lvl[KEY_DOUBLE], key_rel[KEY_SLOWER],
                       key_rel[KEY_FASTER], dec_x[W_PERIOD], dbl_x[W_PERIOD]};

endmodule

// File: tb/tb_rate_counter.sv
// tb_rate_counter: randomised and directed checks of rate_counter against a
// behavioural model (period rules, tick schedule, integer counter arithmetic).
// Two instances share stimulus: one wrapping, one saturating.
module tb_rate_counter;

  localparam int MIN_P   = 4;
  localparam int MAX_P   = 64;
  localparam int RST_P   = 16;
  localparam int STEP_P  = 1;
  localparam int CNT_MAX = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, dir = 1'b1, load = 1'b0;
  logic       key_slower = 1'b0, key_faster = 1'b0, key_halve = 1'b0, key_double = 1'b0;
  logic [7:0] load_value = '0;

  logic [7:0] period_w, count_w, period_s, count_s;
  logic       tick_w, wrap_w, tick_s, wrap_s;

  int checks = 0;
  int errors = 0;

  // Model state: period, enabled-cycle index of next tick, integer counts.
  int m_period, m_ecyc, m_next, m_cnt_w, m_cnt_s;
  bit m_wrap_w, m_wrap_s, m_prev_h, m_prev_d;

  always #5 clk = ~clk;

  rate_counter #(
    .W_CNT(8), .W_PERIOD(8), .MIN_PERIOD(MIN_P), .MAX_PERIOD(MAX_P),
    .RESET_PERIOD(RST_P), .STEP(STEP_P), .WRAP(1)
  ) dut_w (
    .clk(clk), .rst(rst), .en(en), .key_slower(key_slower), .key_faster(key_faster),
    .key_halve(key_halve), .key_double(key_double), .dir(dir), .load(load),
    .load_value(load_value), .period(period_w), .tick(tick_w), .count(count_w), .wrap(wrap_w)
  );

  rate_counter #(
    .W_CNT(8), .W_PERIOD(8), .MIN_PERIOD(MIN_P), .MAX_PERIOD(MAX_P),
    .RESET_PERIOD(RST_P), .STEP(STEP_P), .WRAP(0)
  ) dut_s (
    .clk(clk), .rst(rst), .en(en), .key_slower(key_slower), .key_faster(key_faster),
    .key_halve(key_halve), .key_double(key_double), .dir(dir), .load(load),
    .load_value(load_value), .period(period_s), .tick(tick_s), .count(count_s), .wrap(wrap_s)
  );

  function automatic bit m_tick();
    return en && (m_ecyc == m_next);
  endfunction

  function automatic int adv(input int c, input bit up, input bit wrap_mode, output bit hit);
    hit = 1'b0;
    if (up) begin
      if (c == CNT_MAX) begin
        hit = 1'b1;
        return wrap_mode ? 0 : CNT_MAX;
      end
      return c + 1;
    end
    if (c == 0) begin
      hit = 1'b1;
      return wrap_mode ? CNT_MAX : 0;
    end
    return c - 1;
  endfunction

  task automatic m_reset();
    m_period = RST_P;
    m_ecyc   = 0;
    m_next   = 0;
    m_cnt_w  = 0;
    m_cnt_s  = 0;
    m_wrap_w = 1'b0;
    m_wrap_s = 1'b0;
    m_prev_h = 1'b0;
    m_prev_d = 1'b0;
  endtask

  // Advance DUTs and model by one clock with the inputs currently applied.
  task automatic step();
    bit t, rel_h, rel_d, hw, hs;
    int np, cw, cs;
    t     = m_tick();
    rel_h = m_prev_h && !key_halve;
    rel_d = m_prev_d && !key_double;
    np    = m_period;
    if (key_slower && m_period < MAX_P)      np = (m_period + STEP_P > MAX_P) ? MAX_P : m_period + STEP_P;
    else if (key_faster && m_period > MIN_P) np = (m_period - STEP_P < MIN_P) ? MIN_P : m_period - STEP_P;
    else if (rel_h)                          np = (2 * m_period > MAX_P) ? MAX_P : 2 * m_period;
    else if (rel_d)                          np = (m_period / 2 < MIN_P) ? MIN_P : m_period / 2;
    cw = m_cnt_w; cs = m_cnt_s; hw = 1'b0; hs = 1'b0;
    if (load) begin
      cw = int'(load_value);
      cs = int'(load_value);
    end else if (t) begin
      cw = adv(m_cnt_w, dir, 1'b1, hw);
      cs = adv(m_cnt_s, dir, 1'b0, hs);
    end
    if (t)  m_next = m_ecyc + m_period;
    if (en) m_ecyc++;
    @(posedge clk);
    #1;
    m_period = np;
    m_cnt_w  = cw;
    m_cnt_s  = cs;
    m_wrap_w = hw;
    m_wrap_s = hs;
    m_prev_h = key_halve;
    m_prev_d = key_double;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    en = 1'b1; dir = 1'b1; load = 1'b0; load_value = '0;
    key_slower = 1'b0; key_faster = 1'b0; key_halve = 1'b0; key_double = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en = 1'b1;
    #12;
    checks++;
    if ({period_w, count_w, wrap_w, period_s, count_s, wrap_s} !== {8'd16, 8'd0, 1'b0, 8'd16, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got period %0d/%0d count %0d/%0d wrap %b/%b, expected 16 0 0",
               period_w, period_s, count_w, count_s, wrap_w, wrap_s);
    end
  endtask

  task automatic test_tick_basic();
    bit exp_t;
    do_reset();
    for (int i = 0; i <= 32; i++) begin
      exp_t = (i % 16 == 0);
      checks++;
      if (tick_w !== exp_t || tick_s !== exp_t) begin
        errors++;
        $display("FAIL basic_tick cycle %0d: got %b/%b expected %b", i, tick_w, tick_s, exp_t);
      end
      if (exp_t) begin
        checks++;
        if (count_w !== 8'(i / 16)) begin
          errors++;
          $display("FAIL basic_count cycle %0d: got %0d expected %0d", i, count_w, i / 16);
        end
      end
      step();
    end
  endtask

  task automatic test_halve_double();
    int exp_h[3] = '{32, 64, 64};
    int exp_d[5] = '{32, 16, 8, 4, 4};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      key_halve = 1'b1; step();
      key_halve = 1'b0; step();
      checks++;
      if (period_w !== 8'(exp_h[i]) || period_s !== 8'(m_period)) begin
        errors++;
        $display("FAIL halve %0d: got %0d expected %0d", i, period_w, exp_h[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      key_double = 1'b1; step();
      key_double = 1'b0; step();
      checks++;
      if (period_w !== 8'(exp_d[i]) || period_s !== 8'(m_period)) begin
        errors++;
        $display("FAIL double %0d: got %0d expected %0d", i, period_w, exp_d[i]);
      end
    end
  endtask

  task automatic test_hold_priority();
    int exp_p;
    do_reset();
    key_slower = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      exp_p = (RST_P + i + 1 > MAX_P) ? MAX_P : RST_P + i + 1;
      checks++;
      if (period_w !== 8'(exp_p)) begin
        errors++;
        $display("FAIL hold_slower step %0d: got %0d expected %0d", i, period_w, exp_p);
      end
    end
    key_slower = 1'b0; key_faster = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (period_w !== 8'd54) begin
      errors++;
      $display("FAIL hold_faster: got %0d expected 54", period_w);
    end
    key_slower = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (period_w !== 8'd57) begin
      errors++;
      $display("FAIL both_held: got %0d expected 57", period_w);
    end
    key_slower = 1'b0; key_halve = 1'b1; step();
    key_halve = 1'b0; step();
    checks++;
    if (period_w !== 8'd55) begin
      errors++;
      $display("FAIL halve_dropped: got %0d expected 55", period_w);
    end
    key_faster = 1'b0; step();
    checks++;
    if (period_w !== 8'd55 || period_s !== 8'(m_period)) begin
      errors++;
      $display("FAIL halve_not_queued: got %0d expected 55", period_w);
    end
  endtask

  task automatic test_wrap_saturate();
    bit t;
    int k;
    do_reset();
    dir = 1'b1; load = 1'b1; load_value = 8'hFE; step(); load = 1'b0;
    checks++;
    if (count_w !== 8'hFE || count_s !== 8'hFE || wrap_w !== 1'b0) begin
      errors++;
      $display("FAIL load_fe: got %h/%h wrap %b expected fe/fe 0", count_w, count_s, wrap_w);
    end
    k = 0;
    for (int i = 0; i < 40; i++) begin
      t = m_tick(); step();
      if (t) begin
        k++;
        checks++;
        if ((k == 1 && {count_w, wrap_w, count_s, wrap_s} !== {8'hFF, 1'b0, 8'hFF, 1'b0}) ||
            (k == 2 && {count_w, wrap_w, count_s, wrap_s} !== {8'h00, 1'b1, 8'hFF, 1'b1})) begin
          errors++;
          $display("FAIL up_limit tick %0d: got w %h/%b s %h/%b", k, count_w, wrap_w, count_s, wrap_s);
        end
      end
    end
    dir = 1'b0; load = 1'b1; load_value = 8'h01; step(); load = 1'b0;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      t = m_tick(); step();
      if (t) begin
        k++;
        checks++;
        if ((k == 1 && {count_w, wrap_w, count_s, wrap_s} !== {8'h00, 1'b0, 8'h00, 1'b0}) ||
            (k == 2 && {count_w, wrap_w, count_s, wrap_s} !== {8'hFF, 1'b1, 8'h00, 1'b1}) ||
            (k == 3 && {count_w, wrap_w, count_s, wrap_s} !== {8'hFE, 1'b0, 8'h00, 1'b1})) begin
          errors++;
          $display("FAIL down_limit tick %0d: got w %h/%b s %h/%b", k, count_w, wrap_w, count_s, wrap_s);
        end
      end
    end
    checks++;
    if (k != 3) begin
      errors++;
      $display("FAIL down_tick_count: got %0d ticks expected 3", k);
    end
  endtask

  task automatic test_period_change_enable();
    bit exp_t;
    do_reset();
    for (int i = 0; i <= 86; i++) begin
      en = !(i >= 50 && i < 55);
      key_halve = (i == 5);
      #1;
      exp_t = (i == 0 || i == 16 || i == 48 || i == 85);
      checks++;
      if (tick_w !== exp_t || tick_s !== exp_t) begin
        errors++;
        $display("FAIL interval_tick cycle %0d: got %b/%b expected %b", i, tick_w, tick_s, exp_t);
      end
      step();
    end
    checks++;
    if (count_w !== 8'd4 || count_s !== 8'(m_cnt_s)) begin
      errors++;
      $display("FAIL interval_count: got %0d expected 4", count_w);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 20; i++) step();
    key_halve = 1'b1; step();
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({period_w, count_w, wrap_w, count_s} !== {8'd16, 8'd0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL mid_reset: got period %0d count %0d/%0d wrap %b expected 16 0 0 0",
               period_w, count_w, count_s, wrap_w);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (period_w !== 8'd16) begin
        errors++;
        $display("FAIL held_through_reset %0d: got %0d expected 16", i, period_w);
      end
    end
    key_halve = 1'b0; step();
    checks++;
    if (period_w !== 8'd32 || period_s !== 8'(m_period)) begin
      errors++;
      $display("FAIL release_after_reset: got %0d expected 32", period_w);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      en         = ($urandom_range(0, 7) != 0);
      dir        = 1'($urandom);
      load       = ($urandom_range(0, 15) == 0);
      load_value = 8'($urandom);
      key_slower = ($urandom_range(0, 7) == 0);
      key_faster = ($urandom_range(0, 7) == 0);
      key_halve  = ($urandom_range(0, 3) == 0);
      key_double = ($urandom_range(0, 3) == 0);
      step();
      #1;
      checks++;
      if ({tick_w, period_w, count_w, wrap_w, tick_s, period_s, count_s, wrap_s} !==
          {m_tick(), 8'(m_period), 8'(m_cnt_w), m_wrap_w, m_tick(), 8'(m_period), 8'(m_cnt_s), m_wrap_s}) begin
        errors++;
        $display("FAIL random cycle %0d: got t%b p%0d c%h/%h w%b/%b expected t%b p%0d c%h/%h w%b/%b",
                 i, tick_w, period_w, count_w, count_s, wrap_w, wrap_s,
                 m_tick(), m_period, m_cnt_w, m_cnt_s, m_wrap_w, m_wrap_s);
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_tick_basic();
    test_halve_double();
    test_hold_priority();
    test_wrap_saturate();
    test_period_change_enable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
